// File: rtl/udp_payload_fifo_if.sv
// udp_payload_fifo_if
//   Bundles the payload FIFO handshake and status signals.
//   master : payload producer / stream consumer side (drives i_*, observes o_*)
//   slave  : the FIFO itself (observes i_*, drives o_*)
//   i_wr/i_wr_data      word push (byte0 = [31:24])
//   i_clr               synchronous flush pulse
//   i_pattern_en        1 = incrementing test pattern replaces FIFO data
//   o_udp_stream/o_udp_vl/i_udp_rd   show-ahead byte stream, one-cycle read strobe
//   o_level/o_full/o_empty           registered word occupancy
//   o_overflow/o_underrun            sticky error flags
interface udp_payload_fifo_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              i_wr;
    logic [31:0]       i_wr_data;
    logic              i_clr;
    logic              i_pattern_en;
    logic [7:0]        o_udp_stream;
    logic              o_udp_vl;
    logic              i_udp_rd;
    logic [ADDR_W:0]   o_level;
    logic              o_full;
    logic              o_empty;
    logic              o_overflow;
    logic              o_underrun;

    modport master (
        output i_wr, i_wr_data, i_clr, i_pattern_en, i_udp_rd,
        input  o_udp_stream, o_udp_vl, o_level, o_full, o_empty, o_overflow, o_underrun
    );

    modport slave (
        input  i_wr, i_wr_data, i_clr, i_pattern_en, i_udp_rd,
        output o_udp_stream, o_udp_vl, o_level, o_full, o_empty, o_overflow, o_underrun
    );
endinterface

// File: rtl/udp_payload_fifo.sv
// udp_payload_fifo
//   32-bit word FIFO feeding the UDP frame builder with a big-endian,
//   show-ahead byte stream. Words flow RAM -> prefetch (s1) -> staging (s0);
//   s0 is unpacked byte by byte. A test-pattern counter can replace the FIFO
//   as the byte source without disturbing FIFO state.
//   clk    tx clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    udp_payload_fifo_if.slave (push, flush, mode, stream, status)
module udp_payload_fifo #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    udp_payload_fifo_if.slave    bus
);
    localparam int unsigned     DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;   // words still in RAM
    logic [ADDR_W:0]   level_q, level_d;       // words in RAM + s1 + s0
    logic              pend_q, pend_d;         // RAM read issued last cycle
    logic [31:0]       s0_q, s0_d, s1_q, s1_d;
    logic              s0_vl_q, s0_vl_d, s1_vl_q, s1_vl_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        pat_q, pat_d;
    logic              pat_en_q, pat_en_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              ovf_q, ovf_d, und_q, und_d;

    logic              wr_ok, issue, rd_fifo, retire;
    logic [7:0]        cur_byte;

    // A RAM read is only issued when s1 is empty and nothing is in flight,
    // so a returning word always has a free slot in s1 or s0.
    always_comb begin
        wr_ok   = bus.i_wr && !full_q && !bus.i_clr;
        issue   = (ram_cnt_q != '0) && !pend_q && !s1_vl_q && !bus.i_clr;
        rd_fifo = bus.i_udp_rd && !pat_en_q && s0_vl_q;
        retire  = rd_fifo && (idx_q == 2'd3);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        level_d   = level_q;
        pend_d    = issue;
        s0_d      = s0_q;
        s0_vl_d   = s0_vl_q;
        s1_d      = s1_q;
        s1_vl_d   = s1_vl_q;
        idx_d     = idx_q;
        pat_d     = pat_q;
        pat_en_d  = bus.i_pattern_en;
        ovf_d     = ovf_q;
        und_d     = und_q;

        if (bus.i_clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            level_d   = '0;
            pend_d    = 1'b0;
            s0_d      = '0;
            s0_vl_d   = 1'b0;
            s1_d      = '0;
            s1_vl_d   = 1'b0;
            idx_d     = '0;
            pat_d     = '0;
            ovf_d     = 1'b0;
            und_d     = 1'b0;
        end else begin
            if (wr_ok)                    wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (issue)                    rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (bus.i_wr && full_q)       ovf_d = 1'b1;
            if (bus.i_udp_rd && !pat_en_q && !s0_vl_q) und_d = 1'b1;
            if (bus.i_udp_rd && pat_en_q) pat_d = pat_q + 8'd1;
            if (rd_fifo)                  idx_d = idx_q + 2'd1;

            if (wr_ok && !issue)          ram_cnt_d = ram_cnt_q + LVL_ONE;
            else if (!wr_ok && issue)     ram_cnt_d = ram_cnt_q - LVL_ONE;

            if (wr_ok && !retire)         level_d = level_q + LVL_ONE;
            else if (!wr_ok && retire)    level_d = level_q - LVL_ONE;

            // Refill s0 from s1 first, else straight from the RAM output so
            // the first word of an idle FIFO skips the prefetch stage.
            if (!s0_vl_q || retire) begin
                if (s1_vl_q) begin
                    s0_d    = s1_q;
                    s0_vl_d = 1'b1;
                    s1_vl_d = 1'b0;
                end else if (pend_q) begin
                    s0_d    = ram_q;
                    s0_vl_d = 1'b1;
                end else begin
                    s0_vl_d = 1'b0;
                end
            end else if (pend_q) begin
                s1_d    = ram_q;
                s1_vl_d = 1'b1;
            end
        end

        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= bus.i_wr_data;
        if (issue) ram_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            level_q   <= '0;
            pend_q    <= 1'b0;
            s0_q      <= '0;
            s0_vl_q   <= 1'b0;
            s1_q      <= '0;
            s1_vl_q   <= 1'b0;
            idx_q     <= '0;
            pat_q     <= '0;
            pat_en_q  <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            und_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            level_q   <= level_d;
            pend_q    <= pend_d;
            s0_q      <= s0_d;
            s0_vl_q   <= s0_vl_d;
            s1_q      <= s1_d;
            s1_vl_q   <= s1_vl_d;
            idx_q     <= idx_d;
            pat_q     <= pat_d;
            pat_en_q  <= pat_en_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            und_q     <= und_d;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = s0_q[31:24];
            2'd1:    cur_byte = s0_q[23:16];
            2'd2:    cur_byte = s0_q[15:8];
            default: cur_byte = s0_q[7:0];
        endcase
    end

    assign bus.o_udp_vl     = pat_en_q | s0_vl_q;
    assign bus.o_udp_stream = pat_en_q ? pat_q : (s0_vl_q ? cur_byte : 8'h00);
    assign bus.o_level      = level_q;
    assign bus.o_full       = full_q;
    assign bus.o_empty      = empty_q;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_underrun   = und_q;
endmodule

// File: tb/tb_udp_payload_fifo.sv
module tb_udp_payload_fifo;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    udp_payload_fifo_if #(.ADDR_W(9)) bif ();

    udp_payload_fifo #(.ADDR_W(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] wgen(input int i);
        logic [15:0] v;
        v = i[15:0];
        return {v[7:0], ~v[7:0], v[15:8] ^ 8'h3C, v[7:0] + 8'h80};
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int b);
        logic [31:0] s;
        s = w >> (8 * (3 - b));
        return s[7:0];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bif.i_wr = 1'b0; bif.i_wr_data = '0; bif.i_clr = 1'b0;
        bif.i_pattern_en = 1'b0; bif.i_udp_rd = 1'b0;
        step(); step();
        compared++;
        if (bif.o_udp_vl !== 1'b0 || bif.o_udp_stream !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_stream: vl=%b data=%h expected vl=0 data=00", bif.o_udp_vl, bif.o_udp_stream);
        end
        compared++;
        if (bif.o_level !== 10'd0 || bif.o_full !== 1'b0 || bif.o_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_level: level=%0d full=%b empty=%b expected 0/0/1", bif.o_level, bif.o_full, bif.o_empty);
        end
        compared++;
        if (bif.o_overflow !== 1'b0 || bif.o_underrun !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_flags: ovf=%b und=%b expected 0/0", bif.o_overflow, bif.o_underrun);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [8];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        bif.i_wr = 1'b1; bif.i_wr_data = 32'h11223344; step();
        bif.i_wr_data = 32'h55667788; step();
        bif.i_wr = 1'b0; step(); step(); step();
        compared++;
        if (bif.o_level !== 10'd2 || bif.o_empty !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_level2: level=%0d empty=%b expected 2/0", bif.o_level, bif.o_empty);
        end
        for (int k = 0; k < 8; k++) begin
            compared++;
            if (bif.o_udp_vl !== 1'b1 || bif.o_udp_stream !== exp_b[k]) begin
                mismatched++;
                $display("FAIL basic_byte%0d: vl=%b data=%h expected vl=1 data=%h", k, bif.o_udp_vl, bif.o_udp_stream, exp_b[k]);
            end
            bif.i_udp_rd = 1'b1;
            step();
        end
        bif.i_udp_rd = 1'b0;
        compared++;
        if (bif.o_udp_vl !== 1'b0 || bif.o_level !== 10'd0 || bif.o_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_drained: vl=%b level=%0d empty=%b expected 0/0/1", bif.o_udp_vl, bif.o_level, bif.o_empty);
        end
        step();
    endtask

    task automatic test_fill_overflow();
        int bad;
        for (int i = 0; i <= 512; i++) begin
            if (i == 512) begin
                compared++;
                if (bif.o_full !== 1'b1 || bif.o_overflow !== 1'b0 || bif.o_level !== 10'd512) begin
                    mismatched++;
                    $display("FAIL fill_exact: full=%b ovf=%b level=%0d expected 1/0/512", bif.o_full, bif.o_overflow, bif.o_level);
                end
            end
            bif.i_wr = 1'b1; bif.i_wr_data = wgen(i);
            step();
        end
        bif.i_wr = 1'b0;
        step();
        compared++;
        if (bif.o_full !== 1'b1 || bif.o_overflow !== 1'b1 || bif.o_level !== 10'd512) begin
            mismatched++;
            $display("FAIL fill_drop: full=%b ovf=%b level=%0d expected 1/1/512", bif.o_full, bif.o_overflow, bif.o_level);
        end
        bad = 0;
        for (int b = 0; b < 2048; b++) begin
            compared++;
            if (bif.o_udp_vl !== 1'b1 || bif.o_udp_stream !== byte_of(wgen(b / 4), b % 4)) begin
                mismatched++;
                if (bad < 8)
                    $display("FAIL drain_byte%0d: vl=%b data=%h expected vl=1 data=%h", b, bif.o_udp_vl, bif.o_udp_stream, byte_of(wgen(b / 4), b % 4));
                bad++;
            end
            bif.i_udp_rd = 1'b1;
            step();
        end
        bif.i_udp_rd = 1'b0;
        compared++;
        if (bif.o_udp_vl !== 1'b0 || bif.o_empty !== 1'b1 || bif.o_underrun !== 1'b0 || bif.o_overflow !== 1'b1) begin
            mismatched++;
            $display("FAIL drain_end: vl=%b empty=%b und=%b ovf=%b expected 0/1/0/1", bif.o_udp_vl, bif.o_empty, bif.o_underrun, bif.o_overflow);
        end
        step();
    endtask

    task automatic test_underrun_clr();
        bif.i_udp_rd = 1'b1; step();
        bif.i_udp_rd = 1'b0;
        compared++;
        if (bif.o_underrun !== 1'b1 || bif.o_udp_stream !== 8'h00 || bif.o_level !== 10'd0) begin
            mismatched++;
            $display("FAIL underrun_set: und=%b data=%h level=%0d expected 1/00/0", bif.o_underrun, bif.o_udp_stream, bif.o_level);
        end
        bif.i_clr = 1'b1; step();
        bif.i_clr = 1'b0;
        compared++;
        if (bif.o_underrun !== 1'b0 || bif.o_overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL clr_flags: und=%b ovf=%b expected 0/0", bif.o_underrun, bif.o_overflow);
        end
        step();
    endtask

    task automatic test_pattern();
        int bad;
        logic [7:0] e;
        bif.i_pattern_en = 1'b1; step();
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            e = k[7:0];
            compared++;
            if (bif.o_udp_vl !== 1'b1 || bif.o_udp_stream !== e) begin
                mismatched++;
                if (bad < 8)
                    $display("FAIL pattern_byte%0d: vl=%b data=%h expected vl=1 data=%h", k, bif.o_udp_vl, bif.o_udp_stream, e);
                bad++;
            end
            bif.i_udp_rd = 1'b1;
            step();
        end
        bif.i_udp_rd = 1'b0;
        compared++;
        if (bif.o_udp_stream !== 8'h2C || bif.o_underrun !== 1'b0 || bif.o_level !== 10'd0) begin
            mismatched++;
            $display("FAIL pattern_end: data=%h und=%b level=%0d expected 2c/0/0", bif.o_udp_stream, bif.o_underrun, bif.o_level);
        end
        bif.i_pattern_en = 1'b0;
        bif.i_wr = 1'b1; bif.i_wr_data = 32'hDEADBEEF; step();
        bif.i_wr = 1'b0; step(); step(); step();
        compared++;
        if (bif.o_udp_vl !== 1'b1 || bif.o_udp_stream !== 8'hDE || bif.o_level !== 10'd1) begin
            mismatched++;
            $display("FAIL mode_back: vl=%b data=%h level=%0d expected 1/de/1", bif.o_udp_vl, bif.o_udp_stream, bif.o_level);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pre [4];
        int nwords;
        int b;
        int j;
        int bad;
        pre = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (bif.o_udp_vl !== 1'b1 || bif.o_udp_stream !== pre[k]) begin
                mismatched++;
                $display("FAIL preload_byte%0d: vl=%b data=%h expected vl=1 data=%h", k, bif.o_udp_vl, bif.o_udp_stream, pre[k]);
            end
            bif.i_udp_rd = 1'b1;
            step();
        end
        bif.i_udp_rd = 1'b0;
        step();
        // 600 words starting at address 1: the pointers wrap past 511.
        nwords = 600;
        b = 0; j = 0; bad = 0;
        for (int c = 0; c < nwords * 4 + 3; c++) begin
            if (c % 4 == 0 && j < nwords) begin
                bif.i_wr = 1'b1; bif.i_wr_data = wgen(j + 1000); j++;
            end else begin
                bif.i_wr = 1'b0;
            end
            if (c >= 3 && b < nwords * 4) begin
                compared++;
                if (bif.o_udp_vl !== 1'b1 || bif.o_udp_stream !== byte_of(wgen(b / 4 + 1000), b % 4)
                    || bif.o_level < 10'd1 || bif.o_level > 10'd2
                    || bif.o_overflow !== 1'b0 || bif.o_underrun !== 1'b0) begin
                    mismatched++;
                    if (bad < 8)
                        $display("FAIL stream_byte%0d: vl=%b data=%h level=%0d ovf=%b und=%b expected vl=1 data=%h level=1..2 flags=0",
                                 b, bif.o_udp_vl, bif.o_udp_stream, bif.o_level, bif.o_overflow, bif.o_underrun,
                                 byte_of(wgen(b / 4 + 1000), b % 4));
                    bad++;
                end
                bif.i_udp_rd = 1'b1;
                b++;
            end else begin
                bif.i_udp_rd = 1'b0;
            end
            step();
        end
        bif.i_wr = 1'b0; bif.i_udp_rd = 1'b0;
        step();
        compared++;
        if (bif.o_udp_vl !== 1'b0 || bif.o_empty !== 1'b1 || bif.o_overflow !== 1'b0 || bif.o_underrun !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_end: vl=%b empty=%b ovf=%b und=%b expected 0/1/0/0", bif.o_udp_vl, bif.o_empty, bif.o_overflow, bif.o_underrun);
        end
    endtask

    task automatic test_clr_and_reset();
        bif.i_wr = 1'b1;
        bif.i_wr_data = 32'hA1A2A3A4; step();
        bif.i_wr_data = 32'hB1B2B3B4; step();
        bif.i_wr_data = 32'hC1C2C3C4; step();
        bif.i_wr = 1'b0;
        step(); step(); step(); step(); step();
        compared++;
        if (bif.o_level !== 10'd3 || bif.o_udp_stream !== 8'hA1) begin
            mismatched++;
            $display("FAIL three_words: level=%0d data=%h expected 3/a1", bif.o_level, bif.o_udp_stream);
        end
        bif.i_udp_rd = 1'b1; step(); step(); step();
        // Last byte of the word retires while a new word is written.
        bif.i_wr = 1'b1; bif.i_wr_data = 32'hD1D2D3D4; step();
        bif.i_wr = 1'b0; bif.i_udp_rd = 1'b0;
        compared++;
        if (bif.o_level !== 10'd3 || bif.o_udp_vl !== 1'b1 || bif.o_udp_stream !== 8'hB1) begin
            mismatched++;
            $display("FAIL write_retire: level=%0d vl=%b data=%h expected 3/1/b1", bif.o_level, bif.o_udp_vl, bif.o_udp_stream);
        end
        bif.i_clr = 1'b1; bif.i_wr = 1'b1; bif.i_wr_data = 32'hE1E2E3E4; bif.i_udp_rd = 1'b1;
        step();
        bif.i_clr = 1'b0; bif.i_wr = 1'b0; bif.i_udp_rd = 1'b0;
        compared++;
        if (bif.o_level !== 10'd0 || bif.o_udp_vl !== 1'b0 || bif.o_overflow !== 1'b0
            || bif.o_empty !== 1'b1 || bif.o_full !== 1'b0) begin
            mismatched++;
            $display("FAIL clr_combo: level=%0d vl=%b ovf=%b empty=%b full=%b expected 0/0/0/1/0",
                     bif.o_level, bif.o_udp_vl, bif.o_overflow, bif.o_empty, bif.o_full);
        end
        step();
        compared++;
        if (bif.o_udp_vl !== 1'b0 || bif.o_level !== 10'd0) begin
            mismatched++;
            $display("FAIL clr_settled: vl=%b level=%0d expected 0/0", bif.o_udp_vl, bif.o_level);
        end
        bif.i_wr = 1'b1;
        bif.i_wr_data = 32'h01020304; step();
        bif.i_wr_data = 32'h05060708; step();
        bif.i_wr = 1'b0; step(); step(); step();
        bif.i_udp_rd = 1'b1; step(); step();
        compared++;
        if (bif.o_udp_vl !== 1'b1 || bif.o_udp_stream !== 8'h03) begin
            mismatched++;
            $display("FAIL pre_reset: vl=%b data=%h expected 1/03", bif.o_udp_vl, bif.o_udp_stream);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (bif.o_udp_vl !== 1'b0 || bif.o_udp_stream !== 8'h00 || bif.o_level !== 10'd0
            || bif.o_empty !== 1'b1 || bif.o_full !== 1'b0
            || bif.o_overflow !== 1'b0 || bif.o_underrun !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: vl=%b data=%h level=%0d empty=%b full=%b ovf=%b und=%b expected 0/00/0/1/0/0/0",
                     bif.o_udp_vl, bif.o_udp_stream, bif.o_level, bif.o_empty, bif.o_full, bif.o_overflow, bif.o_underrun);
        end
        bif.i_udp_rd = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step(); step();
        compared++;
        if (bif.o_udp_vl !== 1'b0 || bif.o_level !== 10'd0 || bif.o_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL after_reset: vl=%b level=%0d empty=%b expected 0/0/1", bif.o_udp_vl, bif.o_level, bif.o_empty);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_basic();
        test_fill_overflow();
        test_underrun_clr();
        test_pattern();
        test_back_to_back();
        test_clr_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
